// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: drives one full-adder cell over WIDTH bits,
// LSB first, and registers {C,S} = A + B + C0 when the last bit is processed.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for START; operands are captured on the accepting edge
// ST_RUN  | one operand bit per clock through the cell; carry is held in a flop
// ST_DONE | one-cycle DONE pulse; S/C already hold the new result
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             C
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s_bit, c_bit;
  logic             accept, last_bit;

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_bit  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt == LAST) begin
          last_bit  = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The single full-adder cell and the result register's next value.
  always_comb begin
    s_bit            = a_sh[0] ^ b_sh[0] ^ carry;
    c_bit            = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    res_nxt          = res >> 1;
    res_nxt[WIDTH-1] = s_bit;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      S     <= '0;
      C     <= 1'b0;
    end else if (accept) begin
      a_sh  <= A;
      b_sh  <= B;
      carry <= C0;
      cnt   <= '0;
    end else if (state == ST_RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      res   <= res_nxt;
      carry <= c_bit;
      cnt   <= cnt + 1'b1;
      // Published outputs only move on the final bit, so S/C hold through RUN.
      if (last_bit) begin
        S <= res_nxt;
        C <= c_bit;
      end
    end
  end

  assign BUSY = (state != ST_IDLE);
  assign DONE = (state == ST_DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: an 8-bit and a 1-bit instance checked against
// plain A+B+C0 arithmetic and the WIDTH+2 cycle transaction timing.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst8, start8, c08, busy8, done8, c8;
  logic [7:0] a8, b8, s8;
  logic       rst1, start1, c01, busy1, done1, c1;
  logic [0:0] a1, b1, s1;

  int checks   = 0;
  int failures = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst8), .START(start8), .A(a8), .B(b8), .C0(c08),
    .BUSY(busy8), .DONE(done8), .S(s8), .C(c8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .CLK(clk), .RST(rst1), .START(start1), .A(a1), .B(b1), .C0(c01),
    .BUSY(busy1), .DONE(done1), .S(s1), .C(c1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 8-bit operation; inputs (including START) are scrambled while busy
  // since they must be ignored until the unit is idle again.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c0, input string tag);
    logic [8:0] expv;
    int n;
    int busy_cnt;
    expv = 9'(a) + 9'(b) + 9'(c0);
    a8 = a; b8 = b; c08 = c0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n = 0;
    busy_cnt = busy8 ? 1 : 0;
    while (!done8 && n < 40) begin
      a8 = 8'($urandom); b8 = 8'($urandom); c08 = 1'($urandom); start8 = 1'($urandom);
      tick();
      n++;
      if (busy8) busy_cnt++;
    end
    check({tag, "_latency"}, 64'(n), 64'd8);
    check({tag, "_s"}, 64'(s8), 64'(expv[7:0]));
    check({tag, "_c"}, 64'(c8), 64'(expv[8]));
    start8 = 1'b0;
    tick();
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd9);
    check({tag, "_idle_busy"}, 64'(busy8), 64'd0);
    check({tag, "_idle_done"}, 64'(done8), 64'd0);
  endtask

  initial begin
    logic [8:0] expv;
    logic [1:0] expv1;
    logic [7:0] ha [30];
    logic [7:0] hb [30];
    logic       hc [30];
    int         done_cnt;
    int         busy_cnt;

    rst8 = 1'b1; rst1 = 1'b1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c08 = 1'b0;
    start1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;  c01 = 1'b0;
    tick();
    tick();
    rst8 = 1'b0; rst1 = 1'b0;
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_s8",    64'(s8),    64'd0);
    check("rst_c8",    64'(c8),    64'd0);
    check("rst_busy1", 64'(busy1), 64'd0);
    check("rst_s1",    64'(s1),    64'd0);

    op8(8'h5A, 8'h3C, 1'b0, "add_5a_3c");
    check("add_5a_3c_const", 64'(s8), 64'h96);
    op8(8'hFF, 8'h01, 1'b0, "add_ff_01");
    check("add_ff_01_const", 64'({c8, s8}), 64'h100);
    op8(8'hFF, 8'hFF, 1'b1, "add_ff_ff_1");
    check("add_ff_ff_1_const", 64'({c8, s8}), 64'h1FF);

    // START held through RUN and DONE of 0x10+0x20 must not start another op.
    a8 = 8'h10; b8 = 8'h20; c08 = 1'b0; start8 = 1'b1;
    tick();
    a8 = 8'h01; b8 = 8'h01;
    done_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (done8) done_cnt++;
      if (i == 7) check("ign_done_time", 64'(done8), 64'd1);
    end
    start8 = 1'b0;
    check("ign_busy",     64'(busy8),    64'd0);
    check("ign_s",        64'(s8),       64'h30);
    check("ign_c",        64'(c8),       64'd0);
    check("ign_done_cnt", 64'(done_cnt), 64'd1);
    tick();
    check("ign_still_idle", 64'(busy8), 64'd0);

    // Reset on the 4th RUN cycle of 0xAA+0x55, with START raised on the same edge.
    a8 = 8'hAA; b8 = 8'h55; c08 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst8 = 1'b1; start8 = 1'b1;
    tick();
    rst8 = 1'b0; start8 = 1'b0;
    check("abort_busy", 64'(busy8), 64'd0);
    check("abort_done", 64'(done8), 64'd0);
    check("abort_s",    64'(s8),    64'd0);
    check("abort_c",    64'(c8),    64'd0);
    done_cnt = 0;
    busy_cnt = 0;
    repeat (12) begin
      tick();
      if (done8) done_cnt++;
      if (busy8) busy_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_no_busy", 64'(busy_cnt), 64'd0);
    op8(8'h01, 8'h02, 1'b0, "after_abort");
    check("after_abort_const", 64'(s8), 64'h03);

    // START held high with fresh operands every cycle: accepts every 10 edges.
    start8 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      ha[i] = 8'($urandom); hb[i] = 8'($urandom); hc[i] = 1'($urandom);
      a8 = ha[i]; b8 = hb[i]; c08 = hc[i];
      tick();
      check("b2b_done", 64'(done8), 64'((i % 10) == 8));
      check("b2b_busy", 64'(busy8), 64'((i % 10) != 9));
      if ((i % 10) == 8) begin
        expv = 9'(ha[i-8]) + 9'(hb[i-8]) + 9'(hc[i-8]);
        check("b2b_sum", 64'({c8, s8}), 64'(expv));
      end
    end
    start8 = 1'b0;
    tick();
    check("b2b_end_idle", 64'(busy8), 64'd0);

    for (int i = 0; i < 16; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), "rand");
    end

    // WIDTH=1 instance: exhaustive over all input combinations.
    for (int v = 0; v < 8; v++) begin
      a1 = v[0]; b1 = v[1]; c01 = v[2];
      expv1 = 2'(a1) + 2'(b1) + 2'(c01);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check("w1_run_busy", 64'(busy1), 64'd1);
      check("w1_run_done", 64'(done1), 64'd0);
      tick();
      check("w1_done", 64'(done1), 64'd1);
      check("w1_sum",  64'({c1, s1}), 64'(expv1));
      tick();
      check("w1_idle", 64'(busy1), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
